// File: rtl/stopwatch_time_keeper.sv
// rtl/stopwatch_time_keeper.sv - accumulates sub-second ticks into mm:ss.hh BCD time with optional lap hold
// Optional lap hold feature: define STOPWATCH_LAP_HOLD_EN to build the lap FSM and hold registers.
module stopwatch_time_keeper #(
  parameter int SUB_MAX = 9999,
  parameter int MIN_MAX = 59
) (
  input  logic        clk_10000Hz,
  input  logic        reset,
  input  logic        count_enable,
  input  logic [13:0] sub_in,
  input  logic        clear,
  input  logic        lap_pulse,
  output logic [3:0]  min_t,
  output logic [3:0]  min_o,
  output logic [3:0]  sec_t,
  output logic [3:0]  sec_o,
  output logic [3:0]  hun_t,
  output logic [3:0]  hun_o,
  output logic        lap_active,
  output logic        overflow
);

  // Time words are packed as {min_t, min_o, sec_t, sec_o, hun_t, hun_o}.
  logic [23:0] live_q;
  logic [23:0] live_n;
  logic [23:0] disp;
  logic [13:0] prev_sub;
  logic        overflow_q;
  logic        overflow_n;
  logic        tick;

  logic [13:0] sub_c;
  logic [13:0] hun_full;
  logic [3:0]  hun_t_n;
  logic [3:0]  hun_o_n;
  logic [3:0]  min_t_q, min_o_q, sec_t_q, sec_o_q;
  logic [3:0]  min_t_n, min_o_n, sec_t_n, sec_o_n;
  logic        min_at_max;

  // An out-of-range upstream value is clamped so the hundredths stay within 0..99.
  assign sub_c    = (sub_in > 14'(SUB_MAX)) ? 14'(SUB_MAX) : sub_in;
  assign hun_full = sub_c / 14'd100;
  assign hun_t_n  = 4'(hun_full / 14'd10);
  assign hun_o_n  = 4'(hun_full % 14'd10);

  // A falling sub-second count means the upstream counter wrapped to a new second.
  assign tick = count_enable && (sub_in < prev_sub);

  assign {min_t_q, min_o_q, sec_t_q, sec_o_q} = live_q[23:8];
  assign min_at_max = (min_t_q == 4'(MIN_MAX / 10)) && (min_o_q == 4'(MIN_MAX % 10));

  // Next live time: BCD seconds/minutes carry chain on tick, hundredths always follow sub_in.
  always_comb begin
    min_t_n    = min_t_q;
    min_o_n    = min_o_q;
    sec_t_n    = sec_t_q;
    sec_o_n    = sec_o_q;
    overflow_n = overflow_q;
    if (tick) begin
      if (sec_o_q == 4'd9) begin
        sec_o_n = 4'd0;
        if (sec_t_q == 4'd5) begin
          sec_t_n = 4'd0;
          if (min_at_max) begin
            min_t_n    = 4'd0;
            min_o_n    = 4'd0;
            overflow_n = 1'b1;
          end else if (min_o_q == 4'd9) begin
            min_o_n = 4'd0;
            min_t_n = min_t_q + 4'd1;
          end else begin
            min_o_n = min_o_q + 4'd1;
          end
        end else begin
          sec_t_n = sec_t_q + 4'd1;
        end
      end else begin
        sec_o_n = sec_o_q + 4'd1;
      end
    end
    live_n = {min_t_n, min_o_n, sec_t_n, sec_o_n, hun_t_n, hun_o_n};
  end

  // Live time, previous sub-second sample and sticky overflow; clear beats everything else.
  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      live_q     <= 24'd0;
      prev_sub   <= 14'd0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      live_q     <= 24'd0;
      prev_sub   <= 14'd0;
      overflow_q <= 1'b0;
    end else begin
      live_q     <= live_n;
      prev_sub   <= sub_in;
      overflow_q <= overflow_n;
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  typedef enum logic {
    LIVE = 1'b0,
    HOLD = 1'b1
  } lap_state_t;

  lap_state_t  state_q;
  lap_state_t  state_n;
  logic [23:0] hold_q;

  // Lap state register.
  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      state_q <= LIVE;
    end else begin
      state_q <= state_n;
    end
  end

  // Lap next state: every lap pulse toggles, clear forces LIVE.
  always_comb begin
    state_n = state_q;
    if (clear) begin
      state_n = LIVE;
    end else if (lap_pulse) begin
      state_n = (state_q == LIVE) ? HOLD : LIVE;
    end
  end

  // Capture the post-edge live time so a tick on the lap edge is included in the frozen value.
  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      hold_q <= 24'd0;
    end else if (clear) begin
      hold_q <= 24'd0;
    end else if ((state_q == LIVE) && lap_pulse) begin
      hold_q <= live_n;
    end
  end

  assign lap_active = (state_q == HOLD);
  assign disp       = lap_active ? hold_q : live_q;
`else
  logic unused_lap;
  assign unused_lap = lap_pulse;
  assign lap_active = 1'b0;
  assign disp       = live_q;
`endif

  assign {min_t, min_o, sec_t, sec_o, hun_t, hun_o} = disp;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_time_keeper.sv
// tb/tb_stopwatch_time_keeper.sv - randomized self-checking bench for stopwatch_time_keeper
`timescale 1ns/1ps
module tb_stopwatch_time_keeper;

  localparam int MIN_MAX   = 59;
  localparam int SUB_MAX   = 9999;
  localparam int WRAP_SECS = (MIN_MAX + 1) * 60;
`ifdef STOPWATCH_LAP_HOLD_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic        clk_10000Hz = 1'b0;
  logic        reset = 1'b1;
  logic        count_enable = 1'b0;
  logic [13:0] sub_in = 14'd0;
  logic        clear = 1'b0;
  logic        lap_pulse = 1'b0;
  logic [3:0]  min_t, min_o, sec_t, sec_o, hun_t, hun_o;
  logic        lap_active;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  // Reference model: elapsed whole seconds plus hundredths, in plain integers.
  int  m_secs, m_hun, m_prev, h_secs, h_hun;
  bit  m_ovf, m_hold;

  stopwatch_time_keeper #(.SUB_MAX(SUB_MAX), .MIN_MAX(MIN_MAX)) dut (
    .clk_10000Hz (clk_10000Hz),
    .reset       (reset),
    .count_enable(count_enable),
    .sub_in      (sub_in),
    .clear       (clear),
    .lap_pulse   (lap_pulse),
    .min_t       (min_t),
    .min_o       (min_o),
    .sec_t       (sec_t),
    .sec_o       (sec_o),
    .hun_t       (hun_t),
    .hun_o       (hun_o),
    .lap_active  (lap_active),
    .overflow    (overflow)
  );

  always #50 clk_10000Hz = ~clk_10000Hz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] to_disp(input int secs, input int hun);
    int mins, s;
    mins = secs / 60;
    s    = secs % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(s / 10), 4'(s % 10), 4'(hun / 10), 4'(hun % 10)};
  endfunction

  function automatic logic [23:0] dut_disp();
    return {min_t, min_o, sec_t, sec_o, hun_t, hun_o};
  endfunction

  task automatic model_reset();
    m_secs = 0; m_hun = 0; m_prev = 0; h_secs = 0; h_hun = 0;
    m_ovf = 1'b0; m_hold = 1'b0;
  endtask

  task automatic model_step(input int sub, input bit en, input bit clr, input bit lap);
    if (clr) begin
      model_reset();
    end else begin
      if (en && (sub < m_prev)) begin
        m_secs++;
        if (m_secs == WRAP_SECS) begin
          m_secs = 0;
          m_ovf  = 1'b1;
        end
      end
      m_hun  = sub / 100;
      m_prev = sub;
      if (LAP_EN && lap) begin
        if (!m_hold) begin
          h_secs = m_secs;
          h_hun  = m_hun;
        end
        m_hold = !m_hold;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".disp"}, 32'(dut_disp()), m_hold ? 32'(to_disp(h_secs, h_hun)) : 32'(to_disp(m_secs, m_hun)));
    check({tag, ".lap"}, 32'(lap_active), 32'(m_hold));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
  endtask

  // One clock: drive inputs away from the edge, step the model at the edge, compare 1 ns later.
  task automatic cycle(input string tag, input int sub, input bit en, input bit clr, input bit lap);
    sub_in       = 14'(sub);
    count_enable = en;
    clear        = clr;
    lap_pulse    = lap;
    @(posedge clk_10000Hz);
    model_step(sub, en, clr, lap);
    #1;
    check_all(tag);
  endtask

  task automatic wrap_second(input string tag);
    cycle(tag, SUB_MAX, 1'b1, 1'b0, 1'b0);
    cycle(tag, 0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int sub_r;
    model_reset();
    repeat (2) @(posedge clk_10000Hz);
    #10;
    check_all("reset");
    reset = 1'b0;

    // Hundredths follow sub_in one cycle later, seconds stay at zero.
    cycle("hun0", 0, 1'b1, 1'b0, 1'b0);
    cycle("hun1234", 1234, 1'b1, 1'b0, 1'b0);
    check("hun1234.val", 32'(dut_disp()), 32'h000012);
    cycle("hun9999", 9999, 1'b1, 1'b0, 1'b0);
    check("hun9999.val", 32'(dut_disp()), 32'h000099);

    // Exactly one second on the 9999->0 wrap, repeated zero does not tick.
    cycle("wrap0", 0, 1'b1, 1'b0, 1'b0);
    check("wrap0.val", 32'(dut_disp()), 32'h000100);
    cycle("wrap0b", 0, 1'b1, 1'b0, 1'b0);
    cycle("wrap1", 1, 1'b1, 1'b0, 1'b0);
    check("wrap1.val", 32'(dut_disp()), 32'h000100);

    // Stopped counter never ticks.
    cycle("stop9999", 9999, 1'b0, 1'b0, 1'b0);
    cycle("stop0", 0, 1'b0, 1'b0, 1'b0);
    check("stop0.val", 32'(dut_disp()), 32'h000100);

    // Minute carry and full overflow wrap.
    cycle("clr", 0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 59; i++) wrap_second("sec_run");
    cycle("pre_min", SUB_MAX, 1'b1, 1'b0, 1'b0);
    check("pre_min.val", 32'(dut_disp()), 32'h005999);
    cycle("min_wrap", 0, 1'b1, 1'b0, 1'b0);
    check("min_wrap.val", 32'(dut_disp()), 32'h010000);
    for (int i = 0; i < WRAP_SECS - 61; i++) wrap_second("min_run");
    cycle("pre_ovf", SUB_MAX, 1'b1, 1'b0, 1'b0);
    check("pre_ovf.val", 32'(dut_disp()), 32'h595999);
    check("pre_ovf.flag", 32'(overflow), 32'd0);
    cycle("ovf_wrap", 0, 1'b1, 1'b0, 1'b0);
    check("ovf_wrap.val", 32'(dut_disp()), 32'h000000);
    check("ovf_wrap.flag", 32'(overflow), 32'd1);
    wrap_second("ovf_sticky");
    check("ovf_sticky.flag", 32'(overflow), 32'd1);
    cycle("ovf_clr", 0, 1'b1, 1'b1, 1'b0);
    check("ovf_clr.flag", 32'(overflow), 32'd0);

    // Lap freeze, resume, coincident tick and clear priority.
    for (int i = 0; i < 3; i++) wrap_second("lap_run");
    cycle("lap_on", 4500, 1'b1, 1'b0, 1'b1);
    if (LAP_EN) begin
      check("lap_on.val", 32'(dut_disp()), 32'h000345);
      check("lap_on.act", 32'(lap_active), 32'd1);
    end else begin
      check("nolap.act", 32'(lap_active), 32'd0);
    end
    cycle("lap_hold", 5000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) wrap_second("lap_hold_run");
    cycle("lap_off", 4500, 1'b1, 1'b0, 1'b1);
    check("lap_off.val", 32'(dut_disp()), 32'h000545);
    check("lap_off.act", 32'(lap_active), 32'd0);
    cycle("lap_tick_pre", SUB_MAX, 1'b1, 1'b0, 1'b0);
    cycle("lap_tick", 0, 1'b1, 1'b0, 1'b1);
    check("lap_tick.val", 32'(dut_disp()), 32'h000600);
    cycle("lap_tick_hold", 2500, 1'b1, 1'b0, 1'b0);
    if (LAP_EN) check("lap_tick_hold.val", 32'(dut_disp()), 32'h000600);
    cycle("clr_lap", 3000, 1'b1, 1'b1, 1'b1);
    check("clr_lap.val", 32'(dut_disp()), 32'h000000);
    check("clr_lap.act", 32'(lap_active), 32'd0);

    // Randomized run with an asynchronous reset in the middle.
    sub_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) sub_r = $urandom_range(0, SUB_MAX);
      else sub_r = (sub_r + $urandom_range(0, 3000)) % (SUB_MAX + 1);
      cycle("rand", sub_r, ($urandom_range(0, 9) != 0), ($urandom_range(0, 199) == 0),
            ($urandom_range(0, 29) == 0));
      if (i == 1500) begin
        reset = 1'b1;
        #5;
        model_reset();
        check_all("async_rst");
        @(posedge clk_10000Hz);
        #10;
        reset = 1'b0;
        check_all("async_rst_hold");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_time_keeper.md
# stopwatch_time_keeper

Downstream stage of the stopwatch sub-second counter. Consumes the 0–9999 sub-second tick count (10 kHz ticks) and accumulates it into a minutes:seconds.hundredths time. Presents six BCD digits to the seven-segment driver. Optionally freezes the displayed time on a lap request while timekeeping continues underneath.

## Interface
- `SUB_MAX`, default 9999: terminal value of the sub-second count.
- `MIN_MAX`, default 59: terminal minutes value; the next increment wraps to 0.
- `clk_10000Hz` in, 1 bit: system clock, 10 kHz; the same clock as the sub-second counter.
- `reset` in, 1 bit: asynchronous, active-high.
- `count_enable` in, 1 bit: run/stop level; the same signal that drives the sub-second counter.
- `sub_in` in, 14 bits: sub-second count from the upstream counter, 0..`SUB_MAX`.
- `clear` in, 1 bit: synchronous clear pulse from the control FSM.
- `lap_pulse` in, 1 bit: single-cycle, debounced lap request.
- `min_t`, `min_o` out, 4 bits each: minutes, BCD tens and ones.
- `sec_t`, `sec_o` out, 4 bits each: seconds, BCD tens and ones.
- `hun_t`, `hun_o` out, 4 bits each: hundredths, BCD tens and ones.
- `lap_active` out, 1 bit: 1 while the display is frozen.
- `overflow` out, 1 bit: sticky flag, set on wrap from 59:59.99.

## Operation
- **Internal registers:**
  - `prev_sub` (14 bits) is loaded from `sub_in` on every edge, regardless of `count_enable`.
  - Live time `live_sec` is 0..59 and `live_min` is 0..`MIN_MAX`, both stored as BCD digit pairs.
  - Live hundredths are computed as floor(`sub_in`/100), giving 0..99, converted to BCD and registered.
- **Second tick:** `tick` = `count_enable` AND (`sub_in` < `prev_sub`).
  - This detects the 9999→0 wrap.
  - A repeated 0 from upstream does not generate a second tick.
- **On tick:**
  - `sec_o` increments, carrying into `sec_t` at 9.
  - Seconds 59 wraps to 00 and increments minutes.
  - Minutes `MIN_MAX` wraps to 00 and sets `overflow`.
- **`clear`:**
  - Zeros `prev_sub`, live time, held time and `overflow`.
  - Forces state LIVE.
  - Has priority over `tick` and `lap_pulse` in the same cycle.
- **Lap FSM:**
  - States LIVE (`lap_active`=0) and HOLD (`lap_active`=1).
  - LIVE→HOLD on `lap_pulse`: the hold registers capture the live time's next-state value from the same edge, so a coincident tick is included.
  - HOLD→LIVE on `lap_pulse`.
  - `lap_pulse` is honoured whether or not `count_enable` is high.
- **Outputs:**
  - LIVE: outputs show the live registers.
  - HOLD: outputs show the hold registers while live keeps counting.
- **`count_enable`=0:**
  - No ticks occur.
  - Hundredths still follow `sub_in`, which holds because the upstream counter is stopped.

## Timing
- **Reset values:** all digits 0, `lap_active`=0, `overflow`=0, `prev_sub`=0, state LIVE.
- **Latency:**
  - `sub_in` sampled at edge N appears on `hun_t`/`hun_o` after edge N (1 cycle).
  - The seconds increment lands on the same edge that samples the wrap, so 59.99→00.00 plus the carry appear together with no intermediate value.
- `lap_active` and the frozen digits change on the edge that samples `lap_pulse`.
- Reset asserted mid-HOLD returns asynchronously to LIVE with all zeros.
- `clear` and `lap_pulse` together: clear wins and the state is LIVE.
- A multi-cycle `lap_pulse` toggles on every high cycle. The debouncer guarantees single-cycle pulses; this block adds no protection.

## Configuration
- **`STOPWATCH_LAP_HOLD_EN` defined:** the lap FSM and hold registers are built as described.
- **Not defined:**
  - No hold registers are built.
  - `lap_pulse` is ignored.
  - `lap_active` is tied to 0.
  - Outputs always show live time.
  - All other behaviour is identical.

## Test plan
- **Hundredths path:** reset, then drive `sub_in`=0,1234,9999 with `count_enable`=1, non-decreasing over the ramp. Expect hundredths 00,12,99 one cycle later and seconds 00 throughout.
- **Second wrap:** drive `sub_in` 9999→0→0→1. Expect exactly one second increment (00→01) on the 9999→0 edge, with hundredths showing 00 on that same edge.
- **Stopped counter:** hold `count_enable`=0 while forcing `sub_in` 9999→0. Expect no second increment.
- **Minute and overflow:**
  - Preload to 00:59.99 and wrap; expect 01:00.00.
  - Preload to 59:59.99 and wrap; expect 00:00.00 with `overflow`=1, which stays set until `clear`.
- **Lap** (with `STOPWATCH_LAP_HOLD_EN`):
  - Pulse lap at 00:03.45; the display freezes at 03.45 with `lap_active`=1.
  - Let 2 s elapse, then pulse again; expect 00:05.45 live and `lap_active`=0.
  - Lap coincident with a tick captures the post-tick value.
- **Clear/reset priority:**
  - `clear` coincident with `lap_pulse` during HOLD gives all zeros and LIVE.
  - Async `reset` mid-count zeros outputs immediately, without waiting for a clock edge.
  - Without the macro, `lap_pulse` has no effect.
